// File: rtl/stack_pc_sequencer.sv
// stack_pc_sequencer: moves a PC_W-bit program counter (and optionally the
// flags) between the core and a WORD_W-bit stack memory port, one word per
// memory handshake. POP assembles the PC for RET/RTI, PUSH splits it for
// CALL/INT. pc_out/flags_out change only once a POP has fully completed.
module stack_pc_sequencer #(
  parameter int              WORD_W   = 16,
  parameter int              PC_W     = 32,
  parameter int              FLAG_W   = 3,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic                                   op,
  input  logic                                   with_flags,
  input  logic [PC_W-1:0]                        pc_in,
  input  logic [FLAG_W-1:0]                      flags_in,
  input  logic [WORD_W-1:0]                      mem_rdata,
  input  logic                                   mem_rvalid,
  input  logic                                   mem_ready,
  output logic                                   mem_re,
  output logic                                   mem_we,
  output logic [WORD_W-1:0]                      mem_wdata,
  output logic                                   flag_sel,
  output logic [$clog2(PC_W/WORD_W+1)-1:0]       word_idx,
  output logic                                   busy,
  output logic                                   done,
  output logic [PC_W-1:0]                        pc_out,
  output logic [FLAG_W-1:0]                      flags_out
);

  localparam int NWORDS = PC_W / WORD_W;
  localparam int CW     = $clog2(NWORDS + 1);
  localparam logic [CW-1:0] NW  = CW'(NWORDS);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_PUSH = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t              state_r;
  logic [CW-1:0]       cnt_r;
  logic                op_r;
  logic                wf_r;
  logic [PC_W-1:0]     pc_snap_r;
  logic [FLAG_W-1:0]   flags_snap_r;
  logic [PC_W-1:0]     shadow_pc_r;
  logic [FLAG_W-1:0]   shadow_flags_r;
  logic [PC_W-1:0]     pc_out_r;
  logic [FLAG_W-1:0]   flags_out_r;
  logic                mem_re_r;
  logic                mem_we_r;
  logic                flag_sel_r;
  logic                busy_r;
  logic                done_r;

  logic [CW-1:0]       last_s;
  logic [CW-1:0]       widx_s;
  logic [PC_W-1:0]     shadow_pc_nxt_s;
  logic [WORD_W-1:0]   mem_wdata_s;

  // Index of the final word of the sequence: NWORDS-1, or NWORDS with the flags word
  always_comb begin
    if (wf_r) begin
      last_s = NW;
    end else begin
      last_s = NW - ONE;
    end
  end

  // Shadow PC with the current read word merged into its slot
  always_comb begin
    shadow_pc_nxt_s = shadow_pc_r;
    for (int k = 0; k < NWORDS; k++) begin
      if (cnt_r == CW'(k)) begin
        shadow_pc_nxt_s[k*WORD_W +: WORD_W] = mem_rdata;
      end else begin
        shadow_pc_nxt_s[k*WORD_W +: WORD_W] = shadow_pc_r[k*WORD_W +: WORD_W];
      end
    end
  end

  // Write data: flags first (zero-extended) when present, then PC words MSW down to LSW
  always_comb begin
    mem_wdata_s = '0;
    widx_s      = NW - ONE - cnt_r + (wf_r ? ONE : '0);
    if (state_r == ST_PUSH) begin
      if (wf_r && (cnt_r == '0)) begin
        mem_wdata_s[FLAG_W-1:0] = flags_snap_r;
      end else begin
        for (int k = 0; k < NWORDS; k++) begin
          if (widx_s == CW'(k)) begin
            mem_wdata_s = pc_snap_r[k*WORD_W +: WORD_W];
          end else begin
            mem_wdata_s = mem_wdata_s;
          end
        end
      end
    end else begin
      mem_wdata_s = '0;
    end
  end

  // Sequencer FSM: snapshot on start, per-word capture/advance, registered status, atomic pc_out update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= ST_IDLE;
      cnt_r          <= '0;
      op_r           <= 1'b0;
      wf_r           <= 1'b0;
      pc_snap_r      <= '0;
      flags_snap_r   <= '0;
      shadow_pc_r    <= '0;
      shadow_flags_r <= '0;
      pc_out_r       <= RESET_PC;
      flags_out_r    <= '0;
      mem_re_r       <= 1'b0;
      mem_we_r       <= 1'b0;
      flag_sel_r     <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r        <= op ? ST_POP : ST_PUSH;
            cnt_r          <= '0;
            op_r           <= op;
            wf_r           <= with_flags;
            pc_snap_r      <= pc_in;
            flags_snap_r   <= flags_in;
            shadow_pc_r    <= '0;
            shadow_flags_r <= '0;
            busy_r         <= 1'b1;
            mem_re_r       <= op;
            mem_we_r       <= ~op;
            // Only PUSH starts on the flags word; POP reaches it last
            flag_sel_r     <= ~op & with_flags;
          end
        end
        ST_POP: begin
          if (mem_rvalid) begin
            if (cnt_r == NW) begin
              shadow_flags_r <= mem_rdata[FLAG_W-1:0];
            end else begin
              shadow_pc_r <= shadow_pc_nxt_s;
            end
            cnt_r <= cnt_r + ONE;
            if (cnt_r == last_s) begin
              state_r    <= ST_DONE;
              busy_r     <= 1'b0;
              mem_re_r   <= 1'b0;
              flag_sel_r <= 1'b0;
              done_r     <= 1'b1;
            end else begin
              flag_sel_r <= wf_r & ((cnt_r + ONE) == NW);
            end
          end
        end
        ST_PUSH: begin
          if (mem_ready) begin
            cnt_r      <= cnt_r + ONE;
            flag_sel_r <= 1'b0;
            if (cnt_r == last_s) begin
              state_r  <= ST_DONE;
              busy_r   <= 1'b0;
              mem_we_r <= 1'b0;
              done_r   <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
          done_r  <= 1'b0;
          if (op_r) begin
            pc_out_r <= shadow_pc_r;
            if (wf_r) begin
              flags_out_r <= shadow_flags_r;
            end
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          cnt_r      <= '0;
          mem_re_r   <= 1'b0;
          mem_we_r   <= 1'b0;
          flag_sel_r <= 1'b0;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
        end
      endcase
    end
  end

  assign mem_re    = mem_re_r;
  assign mem_we    = mem_we_r;
  assign mem_wdata = mem_wdata_s;
  assign flag_sel  = flag_sel_r;
  assign word_idx  = cnt_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pc_out    = pc_out_r;
  assign flags_out = flags_out_r;

endmodule

// File: doc/stack_pc_sequencer.md
Name: stack_pc_sequencer

Overview:
- Parametrised successor of the PC/flags stack accumulator.
- Moves a PC_W-bit program counter, and optionally the flags, between the core and the WORD_W-bit stack memory port.
- Supports both directions: POP assembles the PC on RET/RTI; PUSH splits it on CALL/INT.
- Sits between the control unit and the data-memory stage. Updates pc_out atomically on completion.

Parameters:
WORD_W, 16, memory word width
PC_W, 32, PC width; must be an integer multiple of WORD_W, with NWORDS = PC_W/WORD_W >= 2
FLAG_W, 3, flag register width (FLAG_W <= WORD_W)
RESET_PC, 0, pc_out value after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle request; sampled only in IDLE
op  in  1  1 = POP, 0 = PUSH; sampled with start
with_flags  in  1  include the flags word; sampled with start
pc_in  in  PC_W  PC to push; snapshotted at start
flags_in  in  FLAG_W  flags to push; snapshotted at start
mem_rdata  in  WORD_W  stack read data
mem_rvalid  in  1  mem_rdata valid this cycle
mem_ready  in  1  memory accepts the current write word
mem_re  out  1  read request
mem_we  out  1  write request
mem_wdata  out  WORD_W  write data
flag_sel  out  1  current word is the flags word
word_idx  out  clog2(NWORDS+1)  index of the current word within the sequence
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
pc_out  out  PC_W  last popped PC
flags_out  out  FLAG_W  last popped flags

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - pc_out=RESET_PC, flags_out=0.
  - mem_re=mem_we=flag_sel=busy=done=0, mem_wdata=0, word_idx=0.
  - Shadow accumulator and counter are cleared.
  - A reset mid-operation abandons the sequence; no partial result reaches pc_out.
- States: IDLE, POP, PUSH, DONE.
- Word count: TOTAL = NWORDS + with_flags.
- IDLE:
  - start=1 with op=1 goes to POP; start=1 with op=0 goes to PUSH.
  - On start: counter=0; snapshot op, with_flags, pc_in, flags_in.
  - start outside IDLE is ignored. No queueing.
- POP order (matches PUSH reversed): PC word 0 (least significant), then word 1 … word NWORDS-1, then flags if with_flags.
  - mem_re=1 for the whole time in POP.
  - On each mem_rvalid=1 cycle:
    - PC word k is written into shadow[k*WORD_W +: WORD_W].
    - The flags word: mem_rdata[FLAG_W-1:0] goes into the shadow flags; upper bits are ignored.
    - Counter increments.
  - mem_rvalid=0 stalls; the counter holds.
  - flag_sel=1 while the counter = NWORDS and with_flags=1.
  - After word TOTAL-1 is captured, go to DONE.
- PUSH order: flags word first if with_flags (zero-extended to WORD_W, flag_sel=1), then PC word NWORDS-1 down to word 0.
  - mem_we=1 for the whole time in PUSH.
  - mem_wdata is driven combinationally from the snapshot and the counter.
  - Advance on mem_ready=1. mem_ready=0 holds mem_wdata stable.
  - After the last word is accepted, go to DONE.
- DONE (exactly one cycle):
  - done=1, busy=0, mem_re=mem_we=0.
  - POP: pc_out<=shadow PC. flags_out<=shadow flags only if with_flags; otherwise flags_out holds.
  - PUSH: pc_out and flags_out unchanged.
  - Next state is IDLE. start in the DONE cycle is ignored.
- busy=1 in POP and PUSH.
- word_idx equals the counter.
- mem_rvalid outside POP and mem_ready outside PUSH are ignored.
- Minimum latency:
  - POP: TOTAL+1 cycles from start to done, with rvalid held high.
  - PUSH: TOTAL+1 cycles, with ready held high.
- pc_out never shows a mix of old and new words.

Test Plan:
1. Reset with start=1 and mem_rvalid=1 held -> pc_out=0, flags_out=0, busy=0 until rst releases; no mem_re before start.
2. POP, with_flags=0, rvalid high, rdata 16'h1234 then 16'hABCD -> mem_re for 2 cycles, flag_sel=0 throughout, pc_out stays old until the done pulse, then 32'hABCD1234 on the cycle after DONE; flags_out unchanged.
3. POP, with_flags=1, rdata 16'h0010, 16'h0000, 16'hFFF5, with rvalid=0 for 2 cycles between words 0 and 1 -> busy extends 2 cycles; flag_sel=1 only on the third word; pc_out=32'h00000010, flags_out=3'b101, done asserted once.
4. PUSH, with_flags=1, pc_in=32'hDEAD_BEEF, flags_in=3'b011, ready low on the first cycle -> mem_wdata 16'h0003 held 2 cycles, then 16'hDEAD, then 16'hBEEF; mem_we=3 accepted words; pc_out unchanged.
5. start pulsed during POP and in the DONE cycle -> ignored; exactly one done pulse per accepted start.
6. rst asserted mid-POP after word 0 -> pc_out returns to RESET_PC immediately, no done pulse; a fresh POP afterwards assembles correctly. Repeat with WORD_W=8, PC_W=32 (NWORDS=4) for generic slicing.
